// File: rtl/int2flt_pkg.sv
// Shared types and constants for the int16 -> binary16 converter.
package int2flt_pkg;

  localparam int unsigned EXP_W     = 5;
  localparam int unsigned MANT_W    = 10;
  localparam int unsigned FP16_BIAS = 15;
  // Exponent of a magnitude whose bit 15 is the leading one.
  localparam int unsigned EXP_INIT  = FP16_BIAS + 15;

  typedef enum logic [3:0] {
    StIdle,
    StRdLo,
    StRdHi,
    StAbs,
    StNorm,
    StRound,
    StWrLo,
    StWrHi,
    StDone
  } state_e;

endpackage

// File: rtl/int2flt_round.sv
// Round-to-nearest-even of a normalized 16-bit magnitude to a binary16 exponent/mantissa.
module fp16_round
  import int2flt_pkg::*;
(
  input  logic [15:0]       mag_i,
  input  logic [EXP_W-1:0]  exp_i,
  output logic [EXP_W-1:0]  exp_o,
  output logic [MANT_W-1:0] mant_o
);

  logic              guard;
  logic              sticky;
  logic              round_up;
  logic [MANT_W:0]   mant_sum;

  always_comb begin
    guard    = mag_i[4];
    sticky   = |mag_i[3:0];
    // Ties round toward an even mantissa (lsb is mag_i[5]).
    round_up = guard & (sticky | mag_i[5]);
    mant_sum = {1'b0, mag_i[14:5]} + {{MANT_W{1'b0}}, round_up};
    if (mant_sum[MANT_W]) begin
      mant_o = '0;
      exp_o  = exp_i + {{(EXP_W-1){1'b0}}, 1'b1};
    end else begin
      mant_o = mant_sum[MANT_W-1:0];
      exp_o  = exp_i;
    end
  end

endmodule

// File: rtl/int2flt.sv
// Sequential int16 -> binary16 converter: reads two bytes, normalizes one bit per cycle,
// rounds, writes two bytes back and pulses done.
module int2flt
  import int2flt_pkg::*;
#(
  parameter logic [7:0] IN_ADDR  = 8'd0,
  parameter logic [7:0] OUT_ADDR = 8'd2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  output logic       done_o,
  output logic [7:0] dm_addr_o,
  output logic       dm_wr_en_o,
  output logic [7:0] dm_wdata_o,
  input  logic [7:0] dm_rdata_i
);

  state_e            state_q;
  logic              start_q;
  logic [15:0]       x_q;
  logic              sign_q;
  logic [15:0]       mag_q;
  logic [EXP_W-1:0]  exp_q;
  logic [15:0]       result_q;
  logic              done_q;
  logic [7:0]        addr_q;
  logic              wr_en_q;
  logic [7:0]        wdata_q;

  logic              trigger;
  logic [15:0]       abs_x;
  logic [EXP_W-1:0]  exp_rnd;
  logic [MANT_W-1:0] mant_rnd;
  logic [15:0]       round_res;

  always_comb begin
    trigger   = start_q & ~start_i;
    // 0x8000 negates to itself, which is the correct magnitude.
    abs_x     = x_q[15] ? (~x_q + 16'd1) : x_q;
    round_res = {sign_q, exp_rnd, mant_rnd};
  end

  fp16_round u_round (
    .mag_i  (mag_q),
    .exp_i  (exp_q),
    .exp_o  (exp_rnd),
    .mant_o (mant_rnd)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      start_q  <= 1'b0;
      x_q      <= '0;
      sign_q   <= 1'b0;
      mag_q    <= '0;
      exp_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      addr_q   <= '0;
      wr_en_q  <= 1'b0;
      wdata_q  <= '0;
    end else begin
      start_q <= start_i;
      done_q  <= 1'b0;
      wr_en_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (trigger) begin
            addr_q  <= IN_ADDR;
            state_q <= StRdLo;
          end
        end
        StRdLo: begin
          x_q[7:0] <= dm_rdata_i;
          addr_q   <= IN_ADDR + 8'd1;
          state_q  <= StRdHi;
        end
        StRdHi: begin
          x_q[15:8] <= dm_rdata_i;
          state_q   <= StAbs;
        end
        StAbs: begin
          sign_q <= x_q[15];
          mag_q  <= abs_x;
          exp_q  <= EXP_W'(EXP_INIT);
          if (abs_x == 16'd0) begin
            result_q <= '0;
            addr_q   <= OUT_ADDR;
            wdata_q  <= '0;
            wr_en_q  <= 1'b1;
            state_q  <= StWrLo;
          end else if (abs_x[15]) begin
            state_q <= StRound;
          end else begin
            state_q <= StNorm;
          end
        end
        StNorm: begin
          mag_q <= {mag_q[14:0], 1'b0};
          exp_q <= exp_q - {{(EXP_W-1){1'b0}}, 1'b1};
          if (mag_q[14]) begin
            state_q <= StRound;
          end
        end
        StRound: begin
          result_q <= round_res;
          addr_q   <= OUT_ADDR;
          wdata_q  <= round_res[7:0];
          wr_en_q  <= 1'b1;
          state_q  <= StWrLo;
        end
        StWrLo: begin
          addr_q  <= OUT_ADDR + 8'd1;
          wdata_q <= result_q[15:8];
          wr_en_q <= 1'b1;
          state_q <= StWrHi;
        end
        StWrHi: begin
          done_q  <= 1'b1;
          state_q <= StDone;
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign done_o     = done_q;
  assign dm_addr_o  = addr_q;
  assign dm_wr_en_o = wr_en_q;
  assign dm_wdata_o = wdata_q;

endmodule

// File: tb/tb_int2flt.sv
// Bench for int2flt: directed table, corner sequences and random values against an
// arithmetic binary16 model.
module tb_int2flt;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       done;
  logic [7:0] dm_addr;
  logic       dm_wr_en;
  logic [7:0] dm_wdata;
  logic [7:0] dm_rdata;

  logic [7:0] mem [256];
  int         wr_count = 0;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  int2flt #(
    .IN_ADDR  (8'd0),
    .OUT_ADDR (8'd2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start_i    (start),
    .done_o     (done),
    .dm_addr_o  (dm_addr),
    .dm_wr_en_o (dm_wr_en),
    .dm_wdata_o (dm_wdata),
    .dm_rdata_i (dm_rdata)
  );

  assign dm_rdata = mem[dm_addr];

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (dm_wr_en) begin
      mem[dm_addr] = dm_wdata;
      wr_count = wr_count + 1;
    end
  end

  typedef struct {
    logic [15:0] in;
    logic [15:0] res;
    int          lat;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", name, act, act, exp, exp);
    end
  endtask

  // Exponent of the leading one of a nonzero magnitude.
  function automatic int lead_pos(input int mag);
    int e;
    e = 0;
    while ((mag >> (e + 1)) != 0) e++;
    return e;
  endfunction

  function automatic logic [15:0] ref_fp16(input logic [15:0] v);
    int mag, e, sh, q, r, half;
    logic s;
    s   = v[15];
    mag = s ? 65536 - int'(v) : int'(v);
    if (mag == 0) return 16'h0000;
    e = lead_pos(mag);
    if (e <= 10) begin
      q = mag << (10 - e);
    end else begin
      sh   = e - 10;
      q    = mag >> sh;
      r    = mag - (q << sh);
      half = 1 << (sh - 1);
      if (r > half || (r == half && (q % 2) == 1)) q++;
    end
    if (q == 2048) begin
      q = 1024;
      e++;
    end
    return {s, 5'(e + 15), 10'(q - 1024)};
  endfunction

  function automatic int ref_lat(input logic [15:0] v);
    int mag;
    mag = v[15] ? 65536 - int'(v) : int'(v);
    if (mag == 0) return 6;
    return 7 + (15 - lead_pos(mag));
  endfunction

  task automatic load(input logic [15:0] v);
    mem[0] = v[7:0];
    mem[1] = v[15:8];
    mem[2] = 8'hEE;
    mem[3] = 8'hEE;
  endtask

  // Pulse start; returns the cycle number in which the trigger is visible.
  task automatic pulse(output int t);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = cyc;
  endtask

  task automatic wait_done(input int t0, output int lat);
    lat = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) begin
        lat = cyc - t0;
        break;
      end
    end
  endtask

  task automatic run_op(input logic [15:0] v, input logic [15:0] exp_res, input int exp_lat,
                        input string tag);
    int t, lat, w0;
    load(v);
    w0 = wr_count;
    pulse(t);
    wait_done(t, lat);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " result"}, int'({mem[3], mem[2]}), int'(exp_res));
    check({tag, " writes"}, wr_count - w0, 2);
    @(negedge clk);
    check({tag, " done width"}, int'(done), 0);
  endtask

  vec_t vecs [7];

  initial begin
    int t, lat, w0, ndone;
    logic [15:0] v;

    vecs[0] = '{16'h0001, 16'h3C00, 22};
    vecs[1] = '{16'h0000, 16'h0000, 6};
    vecs[2] = '{16'h8000, 16'hF800, 7};
    vecs[3] = '{16'h7FFF, 16'h7800, 8};
    vecs[4] = '{16'h0801, 16'h6800, 11};
    vecs[5] = '{16'h0803, 16'h6802, 11};
    vecs[6] = '{16'hFFFF, 16'hBC00, 22};

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset done", int'(done), 0);
    check("reset wr_en", int'(dm_wr_en), 0);
    check("reset addr", int'(dm_addr), 0);
    check("reset wdata", int'(dm_wdata), 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].in, vecs[i].res, vecs[i].lat, $sformatf("vec%0d", i));
    end

    // Reset during normalization: no done, no writes, memory untouched.
    load(16'h0001);
    mem[2] = 8'h5A;
    mem[3] = 8'hA5;
    w0 = wr_count;
    pulse(t);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("midreset done", ndone, 0);
    check("midreset writes", wr_count - w0, 0);
    check("midreset mem", int'({mem[3], mem[2]}), 16'hA55A);
    run_op(16'h0001, 16'h3C00, 22, "after reset");

    // Second start while busy is ignored.
    load(16'h0803);
    w0 = wr_count;
    pulse(t);
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    lat = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (lat < 0) lat = cyc - t;
      end
    end
    check("busy dones", ndone, 1);
    check("busy latency", lat, 11);
    check("busy writes", wr_count - w0, 2);
    check("busy result", int'({mem[3], mem[2]}), 16'h6802);

    // Back-to-back trigger in the first idle cycle after done.
    load(16'h0001);
    pulse(t);
    wait_done(t, lat);
    check("b2b first latency", lat, 22);
    check("b2b first result", int'({mem[3], mem[2]}), 16'h3C00);
    mem[0] = 8'hFF;
    mem[1] = 8'h7F;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = cyc;
    wait_done(t, lat);
    check("b2b second latency", lat, 8);
    check("b2b second result", int'({mem[3], mem[2]}), 16'h7800);
    @(negedge clk);

    for (int i = 0; i < 150; i++) begin
      v = 16'($urandom) >> $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) v = -v;
      run_op(v, ref_fp16(v), ref_lat(v), $sformatf("rand 0x%04h", v));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/int2flt.md
# int2flt

Sequential 16-bit two's-complement integer to IEEE-754 half-precision (binary16) converter, the inverse of the float-to-integer program block. On a start request it reads a 16-bit integer from data memory, normalizes it one bit per cycle, rounds to nearest even, and writes the binary16 result back to data memory. It then pulses `done` to the test bench. It sits beside `data_mem` and drives that memory's single address/write port.

## Interface
- `IN_ADDR`, default 8'd0: byte address of the integer low byte; the high byte is at `IN_ADDR+1`.
- `OUT_ADDR`, default 8'd2: byte address of the float low byte; the high byte is at `OUT_ADDR+1`.
- `clk`  in  1: clock; all state changes on the rising edge.
- `reset`  in  1: reset, synchronous, active-high.
- `start`  in  1: request from the test bench. An operation is triggered on its falling edge.
- `done`  out  1: one-cycle acknowledge pulse.
- `dm_addr`  out  8: data memory address.
- `dm_wr_en`  out  1: data memory write enable. Memory writes on the `clk` edge while this is high.
- `dm_wdata`  out  8: data memory write data.
- `dm_rdata`  in  8: data memory read data. Read is combinational from `dm_addr` in the same cycle.

## Operation
- `start_q` is `start` delayed one cycle. A trigger occurs when `start_q && !start`, and is honored only in IDLE. A trigger while busy is ignored and is not queued.
- States:
  - IDLE: on a trigger, go to RD_LO.
  - RD_LO: `dm_addr=IN_ADDR`; latch `x[7:0]`.
  - RD_HI: `dm_addr=IN_ADDR+1`; latch `x[15:8]`.
  - ABS:
    - `sign=x[15]`; `mag` (16-bit unsigned) `= sign ? -x : x`. 0x8000 gives `mag`=0x8000.
    - `exp` (5-bit) `=30` (bias 15 + 15).
    - If `mag==0`: result=0x0000, go to WR_LO.
    - Else if `mag[15]`: go to ROUND.
    - Else: go to NORM.
  - NORM: each cycle `mag<<=1` and `exp-=1`. Leave for ROUND in the cycle the shifted `mag` has bit 15 set. This takes k cycles, k = leading zeros of `mag`, 0..15.
  - ROUND:
    - `mant=mag[14:5]`, `g=mag[4]`, `s=|mag[3:0]`.
    - Increment `mant` if `g && (s || mag[5])`.
    - If `mant` overflows from 0x3FF: `mant=0`, `exp+=1`.
    - Result = `{sign, exp, mant}`. The exponent never exceeds 30, so there is no infinity or NaN path.
  - WR_LO: `dm_addr=OUT_ADDR`, `dm_wdata=result[7:0]`, `dm_wr_en=1`.
  - WR_HI: `dm_addr=OUT_ADDR+1`, `dm_wdata=result[15:8]`, `dm_wr_en=1`.
  - DONE: `done=1`; go to IDLE.
- `dm_wr_en` is high only in WR_LO and WR_HI. Exactly two writes occur per operation.
- Reset, including mid-operation: state goes to IDLE and `start_q`=0. No further memory writes occur and no `done` pulse is produced. A partially written result stays in memory.

## Timing
- Reset values: `done=0`, `dm_wr_en=0`, `dm_addr=0`, `dm_wdata=0`, state IDLE, `start_q=0`.
- Let t be the cycle in which IDLE sees the trigger. Then:
  - RD_LO at t+1, RD_HI at t+2, ABS at t+3.
  - NORM at t+4 .. t+3+k.
  - ROUND at t+4+k, WR_LO at t+5+k, WR_HI at t+6+k.
  - `done` high during t+7+k only.
- Zero input: WR_LO at t+4, `done` at t+6.
- Worst case is input ±1 (k=15): `done` at t+22.
- `done` is never high for more than one cycle. A new trigger can be accepted in the first IDLE cycle after DONE.

## Structure
- Package `int2flt_pkg` contains:
  - the state enum (IDLE, RD_LO, RD_HI, ABS, NORM, ROUND, WR_LO, WR_HI, DONE);
  - `FP16_BIAS=15`;
  - `EXP_INIT=30`;
  - field widths `EXP_W=5` and `MANT_W=10`.
- One combinational sub-module, `fp16_round`: inputs normalized `mag[15:0]` and `exp`; outputs `{exp, mant}` after round-to-nearest-even. The FSM and datapath live in `int2flt`.

## Test plan
- Integer 1 (mem[0]=0x01, mem[1]=0x00) -> mem[2]=0x00, mem[3]=0x3C, `done` at t+22.
- Integer 0 -> mem[3:2]=0x0000, `done` at t+6, exactly two write cycles.
- -32768 (0x8000) -> 0xF800. 32767 (0x7FFF) -> 0x7800, covering round-up with mantissa carry into the exponent.
- Ties: 2049 (0x0801) -> 0x6800 (tie, even, no round). 2051 (0x0803) -> 0x6802 (tie, odd, round up). -1 (0xFFFF) -> 0xBC00.
- Reset asserted during NORM for input 1 -> no `done` and mem[3:2] unchanged. A following trigger with input 1 -> 0x3C00.
- `start` pulsed again while busy -> ignored: single `done`, single result. A back-to-back trigger in the first IDLE cycle after DONE -> accepted.
